// File: rtl/sbox_mask_feeder.sv
// sbox_mask_feeder: front end and back end for a first-order masked 4-bit S-box pipeline.
// Plain nibbles are split into two Boolean shares, fresh randomness is produced every
// cycle by a xorshift64 generator, and the recombined S-box outputs are buffered in a
// small FIFO. The S-box pipeline cannot stall, so credits bound the number of items
// that are in flight or buffered.
module sbox_mask_feeder #(
    parameter int          LATENCY    = 9,
    parameter int          FIFO_DEPTH = 4,
    parameter int          WARMUP     = 16,
    parameter logic [63:0] SEED       = 64'h9E37_79B9_7F4A_7C15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] seed_in,
    input  logic        seed_load,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_data,
    output logic [3:0]  SI_s0,
    output logic [3:0]  SI_s1,
    output logic [20:0] Fresh,
    input  logic [3:0]  SO_s0,
    input  logic [3:0]  SO_s1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_data
);

    localparam int CRW = $clog2(FIFO_DEPTH + 1);
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int WCW = $clog2(WARMUP + 1);

    localparam logic [CRW-1:0] CREDIT_MAX = CRW'(FIFO_DEPTH);
    localparam logic [CRW-1:0] CR_ONE     = CRW'(1);
    localparam logic [PW-1:0]  PTR_LAST   = PW'(FIFO_DEPTH - 1);
    localparam logic [PW-1:0]  PTR_ONE    = PW'(1);
    localparam logic [WCW-1:0] WARM_LAST  = WCW'(WARMUP - 1);
    localparam logic [WCW-1:0] WARM_ONE   = WCW'(1);

    typedef enum logic [0:0] {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    // One xorshift64 step: x ^= x<<13; x ^= x>>7; x ^= x<<17.
    function automatic logic [63:0] xs_step(input logic [63:0] v);
        logic [63:0] t;
        t = v ^ (v << 13);
        t = t ^ (t >> 7);
        t = t ^ (t << 17);
        return t;
    endfunction

    logic [63:0]       x_q;
    logic [63:0]       x_next;
    logic [3:0]        mask;

    state_t            state_q;
    state_t            state_d;
    logic [WCW-1:0]    warm_cnt_q;
    logic [WCW-1:0]    warm_cnt_d;

    logic [CRW-1:0]    credit_q;
    logic [LATENCY:0]  valid_sr;

    logic [3:0]        fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CRW-1:0]    fifo_count;

    logic              accept;
    logic              push;
    logic              pop;
    logic [3:0]        recombined;

    assign x_next     = xs_step(x_q);
    assign mask       = x_next[3:0];
    assign accept     = in_valid & in_ready;
    assign push       = valid_sr[LATENCY];
    assign out_valid  = (fifo_count != '0);
    assign pop        = out_valid & out_ready;
    assign recombined = SO_s0 ^ SO_s1;
    assign out_data   = out_valid ? fifo_mem[rd_ptr] : 4'h0;

    // Generator state and registered Fresh: stepped every cycle, reloaded on a reseed
    // strobe with a zero seed replaced by the default seed so the generator never locks up.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q   <= SEED;
            Fresh <= '0;
        end else begin
            if (seed_load) begin
                x_q <= (seed_in == 64'd0) ? SEED : seed_in;
            end else begin
                x_q <= x_next;
            end
            Fresh <= x_next[24:4];
        end
    end

    // Share registers: an accepted nibble is masked with m, otherwise a fresh sharing of
    // zero is presented so the S-box inputs toggle every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            SI_s0 <= '0;
            SI_s1 <= '0;
        end else begin
            SI_s0 <= accept ? (in_data ^ mask) : mask;
            SI_s1 <= mask;
        end
    end

    // Control state register: warm-up counter and run/warm-up mode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_WARMUP;
            warm_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
        end
    end

    // Next-state and in_ready: a reseed restarts warm-up and blocks acceptance that cycle;
    // in RUN, acceptance depends only on the registered credit count.
    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        in_ready   = 1'b0;
        if (seed_load) begin
            state_d    = ST_WARMUP;
            warm_cnt_d = '0;
        end else begin
            case (state_q)
                ST_WARMUP: begin
                    if (warm_cnt_q == WARM_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        warm_cnt_d = warm_cnt_q + WARM_ONE;
                    end
                end
                ST_RUN: begin
                    in_ready = (credit_q < CREDIT_MAX);
                end
                default: begin
                    state_d    = ST_WARMUP;
                    warm_cnt_d = '0;
                end
            endcase
        end
    end

    // Credit counter: items accepted but not yet popped, in flight or buffered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credit_q <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   credit_q <= credit_q + CR_ONE;
                2'b01:   credit_q <= credit_q - CR_ONE;
                default: credit_q <= credit_q;
            endcase
        end
    end

    // Valid tracking alongside the fixed-latency S-box; the top bit marks the cycle in
    // which the S-box output belongs to an accepted item. Not cleared on reseed so
    // in-flight items still drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_sr <= '0;
        end else begin
            valid_sr <= {valid_sr[LATENCY-1:0], accept};
        end
    end

    // FIFO storage: recombined S-box output written at the tail on push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else if (push) begin
            fifo_mem[wr_ptr] <= recombined;
        end
    end

    // FIFO pointers and occupancy; credits guarantee a push never meets a full buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CR_ONE;
                2'b01:   fifo_count <= fifo_count - CR_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_mask_feeder.sv
// tb_sbox_mask_feeder: directed bench with a behavioural 9-stage masked S-box model,
// a scoreboard of expected outputs, and timing/occupancy models of the feeder.
module tb_sbox_mask_feeder;

    localparam int          LATENCY    = 9;
    localparam int          FIFO_DEPTH = 4;
    localparam int          WARMUP     = 16;
    localparam logic [63:0] SEED       = 64'h9E37_79B9_7F4A_7C15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] seed_in;
    logic        seed_load;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic [3:0]  SI_s0;
    logic [3:0]  SI_s1;
    logic [20:0] Fresh;
    logic [3:0]  SO_s0;
    logic [3:0]  SO_s1;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;

    int num_checks = 0;
    int num_errors = 0;

    logic [3:0]       sb [$];
    int               credit_model = 0;
    int               occ_model = 0;
    logic [LATENCY:0] pend = '0;
    bit               prev_acc = 1'b0;
    logic [3:0]       prev_data = 4'h0;
    bit               mon_acc;
    bit               mon_pop;
    bit               mon_push;
    logic [3:0]       mon_exp;

    logic [3:0] st_v [LATENCY];
    logic [3:0] st_r [LATENCY];

    sbox_mask_feeder #(
        .LATENCY    (LATENCY),
        .FIFO_DEPTH (FIFO_DEPTH),
        .WARMUP     (WARMUP),
        .SEED       (SEED)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_in   (seed_in),
        .seed_load (seed_load),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .SI_s0     (SI_s0),
        .SI_s1     (SI_s1),
        .Fresh     (Fresh),
        .SO_s0     (SO_s0),
        .SO_s1     (SO_s1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] sbox(input logic [3:0] v);
        case (v)
            4'h0: return 4'hC;
            4'h1: return 4'h6;
            4'h2: return 4'h9;
            4'h3: return 4'h0;
            4'h4: return 4'h1;
            4'h5: return 4'hA;
            4'h6: return 4'h2;
            4'h7: return 4'hB;
            4'h8: return 4'h3;
            4'h9: return 4'h8;
            4'hA: return 4'h5;
            4'hB: return 4'hD;
            4'hC: return 4'h4;
            4'hD: return 4'hE;
            4'hE: return 4'h7;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [63:0] xs(input logic [63:0] v);
        logic [63:0] t;
        t = v ^ (v << 13);
        t = t ^ (t >> 7);
        t = t ^ (t << 17);
        return t;
    endfunction

    // Behavioural masked S-box: fixed latency, output re-shared with a random mask.
    always @(posedge clk) begin
        st_v[0] <= sbox(SI_s0 ^ SI_s1);
        st_r[0] <= 4'($urandom);
        for (int i = 1; i < LATENCY; i++) begin
            st_v[i] <= st_v[i-1];
            st_r[i] <= st_r[i-1];
        end
    end
    assign SO_s0 = st_v[LATENCY-1] ^ st_r[LATENCY-1];
    assign SO_s1 = st_r[LATENCY-1];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        num_checks++;
        assert (observed === expected) else begin
            num_errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] d);
        int guard;
        in_valid = 1'b1;
        in_data  = d;
        guard    = 0;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) checkOutput("accept_timeout", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic checkWarmup(input string tag);
        logic [63:0] xm;
        logic [20:0] prev;
        xm   = SEED;
        prev = Fresh;
        for (int k = 1; k <= WARMUP; k++) begin
            tick();
            xm = xs(xm);
            if (k <= 4) begin
                checkOutput({tag, "_fresh"}, Fresh, xm[24:4]);
                checkOutput({tag, "_fresh_changes"}, Fresh != prev, 1);
            end
            prev = Fresh;
            checkOutput({tag, "_ready"}, in_ready, k == WARMUP);
        end
    endtask

    task automatic waitDrain(input string tag);
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            tick();
            guard++;
        end
        checkOutput({tag, "_drain"}, sb.size(), 0);
        tick();
    endtask

    // Monitor: scoreboard, share recombination, out_valid timing and credit limits.
    always begin
        @(negedge clk);
        #3;
        if (!rst_n) begin
            sb.delete();
            credit_model = 0;
            occ_model    = 0;
            pend         = '0;
            prev_acc     = 1'b0;
        end else begin
            checkOutput("si_recombine", SI_s0 ^ SI_s1, prev_acc ? prev_data : 4'h0);
            checkOutput("out_valid_timing", out_valid, occ_model != 0);
            if (credit_model >= FIFO_DEPTH) checkOutput("ready_at_full_credit", in_ready, 0);
            mon_acc  = in_valid && in_ready;
            mon_pop  = out_valid && out_ready;
            mon_push = pend[LATENCY];
            if (mon_pop) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_output", out_valid, 0);
                end else begin
                    mon_exp = sb.pop_front();
                    checkOutput("out_data", out_data, mon_exp);
                end
            end
            if (mon_acc) sb.push_back(sbox(in_data));
            credit_model = credit_model + int'(mon_acc) - int'(mon_pop);
            occ_model = occ_model + int'(mon_push) - int'(occ_model != 0 && out_ready);
            checkOutput("fifo_no_overflow", occ_model <= FIFO_DEPTH, 1);
            pend      = {pend[LATENCY-1:0], mon_acc};
            prev_acc  = mon_acc;
            prev_data = in_data;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0]  single_in  [3];
        logic [3:0]  single_exp [3];
        logic [63:0] xs_seed;
        int          k;
        int          acc_cnt;
        int          more;

        single_in  = '{4'h0, 4'h1, 4'hF};
        single_exp = '{4'hC, 4'h6, 4'hF};

        rst_n     = 1'b0;
        seed_load = 1'b0;
        seed_in   = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        $display("[TB] reset");
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rst_in_ready", in_ready, 0);
            checkOutput("rst_out_valid", out_valid, 0);
            checkOutput("rst_out_data", out_data, 0);
            checkOutput("rst_si_s0", SI_s0, 0);
            checkOutput("rst_si_s1", SI_s1, 0);
            checkOutput("rst_fresh", Fresh, 0);
        end
        rst_n = 1'b1;
        checkWarmup("reset");

        $display("[TB] single items");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(single_in[i]);
            k = 0;
            while (!out_valid && k < 40) begin
                tick();
                k++;
            end
            checkOutput("single_latency", k, 10);
            checkOutput("single_data", out_data, single_exp[i]);
            tick();
            tick();
        end

        $display("[TB] full sweep");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(4'(i));
        end
        waitDrain("sweep");

        $display("[TB] backpressure");
        out_ready = 1'b0;
        acc_cnt   = 0;
        for (int c = 0; c < 30; c++) begin
            in_valid = 1'b1;
            in_data  = 4'(acc_cnt + 5);
            if (in_ready) acc_cnt++;
            tick();
        end
        checkOutput("bp_accepts", acc_cnt, 4);
        checkOutput("bp_ready_low", in_ready, 0);
        checkOutput("bp_fifo_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        more = 0;
        for (int c = 0; c < 15; c++) begin
            in_valid = 1'b1;
            in_data  = 4'(acc_cnt + more + 5);
            if (in_ready) more++;
            tick();
        end
        in_valid = 1'b0;
        checkOutput("bp_one_more", more, 1);
        out_ready = 1'b1;
        waitDrain("bp");

        $display("[TB] reseed mid-stream");
        applyStimulus(4'h3);
        applyStimulus(4'h9);
        seed_in   = 64'd0;
        seed_load = 1'b1;
        #1;
        checkOutput("seed_ready_low", in_ready, 0);
        tick();
        seed_load = 1'b0;
        checkWarmup("reseed");
        waitDrain("reseed");

        $display("[TB] custom seed");
        seed_in   = 64'h0123_4567_89AB_CDEF;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        tick();
        xs_seed = xs(64'h0123_4567_89AB_CDEF);
        checkOutput("seed_custom_fresh", Fresh, xs_seed[24:4]);
        repeat (WARMUP - 2) tick();
        checkOutput("seed_custom_not_ready", in_ready, 0);
        tick();
        checkOutput("seed_custom_ready", in_ready, 1);

        $display("[TB] reset mid-stream");
        applyStimulus(4'h2);
        applyStimulus(4'h4);
        applyStimulus(4'h6);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("midrst_out_valid", out_valid, 0);
        checkWarmup("midrst");
        out_ready = 1'b0;
        acc_cnt   = 0;
        for (int c = 0; c < 25; c++) begin
            in_valid = 1'b1;
            in_data  = 4'(acc_cnt + 10);
            if (in_ready) acc_cnt++;
            tick();
        end
        in_valid = 1'b0;
        checkOutput("midrst_credit", acc_cnt, 4);
        out_ready = 1'b1;
        waitDrain("midrst");

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
